// File: rtl/tile_scan_ctrl_pkg.sv
// Shared definitions for the tile scan sequencer.
// Holds the default frame geometry, the derived band/tile counts, the
// sequencer state encoding and the tag layout carried down the delay line.
package tile_scan_ctrl_pkg;

  // Default frame geometry.
  localparam int IMG_W    = 638;
  localparam int IMG_H    = 482;
  localparam int WIN_W    = 14;
  localparam int WIN_H    = 5;
  localparam int COL_STEP = 12;
  localparam int ROW_STEP = 3;

  // Derived grid size at the default geometry.
  localparam int N_BANDS = (IMG_H - WIN_H) / ROW_STEP + 1;  // 160
  localparam int N_TILES = (IMG_W - WIN_W) / COL_STEP + 1;  // 53

  // Tag and request field widths.
  localparam int BAND_W = 8;
  localparam int TILE_W = 6;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } tsc_state_e;

  typedef struct packed {
    logic [BAND_W-1:0] band;
    logic [TILE_W-1:0] tile;
  } tile_tag_t;

endpackage

// File: rtl/tile_scan_ctrl_if.sv
// Fetch and result bus of the tile scan sequencer.
//   fetch_valid/fetch_ready : tile request handshake to the pixel source
//   fetch_row/fetch_col     : top row and start column of the requested window
//   pipe_in_valid           : datapath capture strobe (accept of a request)
//   valid/cnt_row/cnt_col   : result-aligned token and band/tile tags
//
// Handshake: a request is transferred on every rising edge where
// fetch_valid and fetch_ready are both high. While fetch_valid is high and
// fetch_ready is low, fetch_row/fetch_col hold their value; fetch_valid is
// never withdrawn before the request is accepted.
interface tile_scan_ctrl_if;
  import tile_scan_ctrl_pkg::*;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ROW_W-1:0]  fetch_row;
  logic [COL_W-1:0]  fetch_col;
  logic              pipe_in_valid;
  logic              valid;
  logic [BAND_W-1:0] cnt_row;
  logic [TILE_W-1:0] cnt_col;

  modport master (
    output fetch_valid, fetch_row, fetch_col, pipe_in_valid,
    output valid, cnt_row, cnt_col,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_row, fetch_col, pipe_in_valid,
    input  valid, cnt_row, cnt_col,
    output fetch_ready
  );
endinterface

// File: rtl/tile_scan_ctrl_delay.sv
// LAT-deep shift register of {v, band, tile} tokens matched to the
// datapath latency.
//   in_v/in_tag   : token entering stage 0 (bubbles enter with in_v=0)
//   out_v/out_tag : last stage; out_tag only changes when a valid token
//                   arrives, so it holds the last delivered tag
//   any_valid     : a token will still be in flight after the coming edge
module tag_delay_line
  import tile_scan_ctrl_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_v,
  input  tile_tag_t in_tag,
  output logic      out_v,
  output tile_tag_t out_tag,
  output logic      any_valid
);

  logic [LAT-1:0] v_q;
  tile_tag_t      tag_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      v_q[0] <= in_v;
      if (in_v) tag_q[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        // Tags only move with a valid token, so bubbles leave the tag
        // of the last real result in place at the output.
        if (v_q[i-1]) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_v   = v_q[LAT-1];
  assign out_tag = tag_q[LAT-1];

  // Looks one edge ahead (input plus every stage except the one leaving),
  // so the controller can raise done in the first cycle the line is empty.
  always_comb begin
    any_valid = in_v;
    for (int i = 0; i < LAT - 1; i++) any_valid = any_valid | v_q[i];
  end

endmodule

// File: rtl/tile_scan_ctrl.sv
// Frame-scan sequencer: walks the frame in bands (top down) and tiles
// (right to left), issues one fetch request per tile and carries a band/tile
// token down a delay line aligned with the datapath results.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : frame start request, honoured only in IDLE
//   busy      : high in SCAN and DRAIN
//   done      : one-cycle end-of-frame pulse
//   state_dbg : current sequencer state
//   bus       : fetch handshake and result tags (master side)
module tile_scan_ctrl
  import tile_scan_ctrl_pkg::*;
#(
  parameter int IMG_W    = tile_scan_ctrl_pkg::IMG_W,
  parameter int IMG_H    = tile_scan_ctrl_pkg::IMG_H,
  parameter int COL_STEP = tile_scan_ctrl_pkg::COL_STEP,
  parameter int ROW_STEP = tile_scan_ctrl_pkg::ROW_STEP,
  parameter int WIN_W    = tile_scan_ctrl_pkg::WIN_W,
  parameter int WIN_H    = tile_scan_ctrl_pkg::WIN_H,
  parameter int LAT      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output tsc_state_e              state_dbg,
  tile_scan_ctrl_if.master        bus
);

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - WIN_H);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WIN_W - 1);

  tsc_state_e        state;
  logic              fetch_valid_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [BAND_W-1:0] band_q;
  logic [TILE_W-1:0] tile_q;

  logic              accept;
  logic              line_pending;
  logic              out_v;
  tile_tag_t         in_tag;
  tile_tag_t         out_tag;

  assign accept = fetch_valid_q & bus.fetch_ready;
  assign in_tag = '{band: band_q, tile: tile_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      fetch_valid_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      band_q        <= '0;
      tile_q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_SCAN;
            fetch_valid_q <= 1'b1;
            busy          <= 1'b1;
            row_q         <= '0;
            col_q         <= FIRST_COL;
            band_q        <= '0;
            tile_q        <= '0;
          end
        end
        S_SCAN: begin
          // Position only advances on an accept, so a stalled request
          // stays stable.
          if (accept) begin
            if (col_q == LAST_COL) begin
              if (row_q == LAST_ROW) begin
                state         <= S_DRAIN;
                fetch_valid_q <= 1'b0;
              end else begin
                col_q  <= FIRST_COL;
                tile_q <= '0;
                row_q  <= row_q + ROW_W'(ROW_STEP);
                band_q <= band_q + 1'b1;
              end
            end else begin
              col_q  <= col_q - COL_W'(COL_STEP);
              tile_q <= tile_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!line_pending) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          fetch_valid_q <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  tag_delay_line #(
    .LAT (LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_v      (accept),
    .in_tag    (in_tag),
    .out_v     (out_v),
    .out_tag   (out_tag),
    .any_valid (line_pending)
  );

  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_row     = row_q;
  assign bus.fetch_col     = col_q;
  assign bus.pipe_in_valid = accept;
  assign bus.valid         = out_v;
  assign bus.cnt_row       = out_tag.band;
  assign bus.cnt_col       = out_tag.tile;
  assign state_dbg         = state;

endmodule

// File: tb/tb_tile_scan_ctrl.sv
// Bench for tile_scan_ctrl: a default-geometry instance (LAT=4) followed by
// a reference model of the tile grid, plus a small-geometry instance
// (38x11, LAT=1) exercised with a directed sequence.
module tb_tile_scan_ctrl;
  import tile_scan_ctrl_pkg::*;

  // Frame geometry as the bench understands it.
  localparam int W     = 638;
  localparam int H     = 482;
  localparam int WW    = 14;
  localparam int WH    = 5;
  localparam int CS    = 12;
  localparam int RS    = 3;
  localparam int LAT   = 4;
  localparam int NT    = (W - WW) / CS + 1;
  localparam int NB    = (H - WH) / RS + 1;
  localparam int TOTAL = NT * NB;
  localparam int EXP_W = 46;  // {accept edge[31:0], band[7:0], tile[5:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start, start_s;
  logic busy, done, busy_s, done_s;
  tsc_state_e state_dbg, state_dbg_s;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_scan_ctrl_if fbus ();
  tile_scan_ctrl_if sbus ();

  tile_scan_ctrl #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (fbus)
  );

  tile_scan_ctrl #(.IMG_W(38), .IMG_H(11), .LAT(1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .busy      (busy_s),
    .done      (done_s),
    .state_dbg (state_dbg_s),
    .bus       (sbus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int row_of(input int idx);
    return (idx / NT) * RS;
  endfunction

  function automatic int col_of(input int idx);
    return (W - 1) - (idx % NT) * CS;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  bit  mon_on = 1'b0;
  bit  m_busy = 1'b0;
  int  m_idx = 0;
  int  m_done_edge = -100;
  int  m_band_h = 0, m_tile_h = 0;
  int  v_cnt = 0, first_v = -1, last_v = -1;
  int  done_cnt = 0, done_cyc = -1;

  always @(negedge clk) begin : monitor
    logic [EXP_W-1:0] head;
    bit m_fv, exp_v;
    int e;
    if (rst) begin
      m_busy = 1'b0;
      m_idx = 0;
      m_done_edge = -100;
      m_band_h = 0;
      m_tile_h = 0;
      exp_q.delete();
    end else if (mon_on) begin
      // Outputs for the cycle after edge cyc.
      m_fv = m_busy && (m_idx < TOTAL);
      chk("fetch_valid", fbus.fetch_valid, m_fv);
      if (m_fv) begin
        chk("fetch_row", fbus.fetch_row, row_of(m_idx));
        chk("fetch_col", fbus.fetch_col, col_of(m_idx));
      end
      chk("pipe_in_valid", fbus.pipe_in_valid, m_fv && fbus.fetch_ready);
      chk("busy", busy, m_busy);
      chk("done", done, cyc == m_done_edge);
      exp_v = 1'b0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        exp_v = (int'(head[45:14]) + LAT - 1 == cyc);
      end
      chk("valid", fbus.valid, exp_v);
      if (exp_v) begin
        head = exp_q.pop_front();
        m_band_h = int'(head[13:6]);
        m_tile_h = int'(head[5:0]);
      end
      chk("cnt_row", fbus.cnt_row, m_band_h);
      chk("cnt_col", fbus.cnt_col, m_tile_h);
      if (fbus.valid === 1'b1) begin
        v_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      // What the coming edge does.
      e = cyc + 1;
      if (!m_busy && cyc != m_done_edge) begin
        if (start) begin
          m_busy = 1'b1;
          m_idx = 0;
        end
      end else if (m_fv && fbus.fetch_ready) begin
        exp_q.push_back({32'(e), 8'(m_idx / NT), 6'(m_idx % NT)});
        m_idx++;
        if (m_idx == TOTAL) m_done_edge = e + LAT;
      end
      if (m_busy && e == m_done_edge) m_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rdy, input bit st);
    fbus.fetch_ready = rdy;
    start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_fetch_valid"}, fbus.fetch_valid, 0);
    chk({p, "_pipe_in_valid"}, fbus.pipe_in_valid, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_valid"}, fbus.valid, 0);
    chk({p, "_fetch_row"}, fbus.fetch_row, 0);
    chk({p, "_fetch_col"}, fbus.fetch_col, 0);
    chk({p, "_cnt_row"}, fbus.cnt_row, 0);
    chk({p, "_cnt_col"}, fbus.cnt_col, 0);
    chk({p, "_state"}, state_dbg, S_IDLE);
  endtask

  // Full frame with fetch_ready held high; checks the band wrap and the
  // frame-level timing.
  task automatic frame_fast(input string p);
    int s, n, d0;
    d0 = done_cnt;
    v_cnt = 0;
    first_v = -1;
    last_v = -1;
    done_cyc = -1;
    drive(1'b1, 1'b1);
    s = cyc;
    n = 0;
    while (done_cnt == d0 && n < 9000) begin
      drive(1'b1, 1'b0);
      n++;
      if (cyc == s + 52) begin
        chk({p, "_wrap_row_a"}, fbus.fetch_row, 0);
        chk({p, "_wrap_col_a"}, fbus.fetch_col, 13);
      end
      if (cyc == s + 53) begin
        chk({p, "_wrap_row_b"}, fbus.fetch_row, 3);
        chk({p, "_wrap_col_b"}, fbus.fetch_col, 637);
      end
      if (cyc == s + 56) begin
        chk({p, "_wrap_valid_a"}, fbus.valid, 1);
        chk({p, "_wrap_cnt_row_a"}, fbus.cnt_row, 0);
        chk({p, "_wrap_cnt_col_a"}, fbus.cnt_col, 52);
      end
      if (cyc == s + 57) begin
        chk({p, "_wrap_valid_b"}, fbus.valid, 1);
        chk({p, "_wrap_cnt_row_b"}, fbus.cnt_row, 1);
        chk({p, "_wrap_cnt_col_b"}, fbus.cnt_col, 0);
      end
    end
    chk({p, "_busy_after"}, busy, 0);
    chk({p, "_valid_count"}, v_cnt, 8480);
    chk({p, "_first_valid"}, first_v, s + 4);
    chk({p, "_valid_span"}, last_v - first_v + 1, 8480);
    chk({p, "_done_cycle"}, done_cyc, s + 8484);
  endtask

  // Frame with a 1,0,0,1 ready pattern then random stalls, stray start
  // pulses during SCAN and a start pulse on every DRAIN cycle.
  // stop_after > 0 abandons the frame after that many cycles.
  task automatic frame_rand(input string p, input int stop_after);
    int n, d0;
    bit rdy, st;
    d0 = done_cnt;
    drive(1'b1, 1'b1);
    n = 0;
    while (done_cnt == d0 && n < 20000 && (stop_after == 0 || n < stop_after)) begin
      if (n < 20) rdy = (n % 4 == 0) || (n % 4 == 3);
      else        rdy = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 63) == 0) || (m_busy && m_idx == TOTAL);
      drive(rdy, st);
      n++;
    end
    if (stop_after == 0) begin
      chk({p, "_busy_after"}, busy, 0);
      chk({p, "_done_count"}, done_cnt - d0, 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    fbus.fetch_ready = 1'b0;
    sbus.fetch_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    chk("reset_s_fetch_valid", sbus.fetch_valid, 0);
    chk("reset_s_busy", busy_s, 0);
    chk("reset_s_valid", sbus.valid, 0);
    chk("reset_s_state", state_dbg_s, S_IDLE);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b0, 1'b0);

    frame_fast("frameA");
    repeat (3) drive(1'b0, 1'b0);

    frame_rand("frameB", 0);
    repeat (3) drive(1'b0, 1'b0);

    // Reset in the middle of a scan with tokens in flight.
    frame_rand("frameC", $urandom_range(30, 3000));
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) drive(1'b1, 1'b0);

    frame_fast("frameD");
    drive(1'b0, 1'b0);

    // Small geometry: 3 bands x 3 tiles, LAT=1, ready held high.
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    s = cyc;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      chk("small_edge", cyc - s, j);
      chk("small_fetch_valid", sbus.fetch_valid, j <= 8);
      if (j <= 8) begin
        chk("small_fetch_row", sbus.fetch_row, (j / 3) * 3);
        chk("small_fetch_col", sbus.fetch_col, 37 - (j % 3) * 12);
      end
      chk("small_valid", sbus.valid, (j >= 1) && (j <= 9));
      if (j >= 1 && j <= 9) begin
        chk("small_cnt_row", sbus.cnt_row, (j - 1) / 3);
        chk("small_cnt_col", sbus.cnt_col, (j - 1) % 3);
      end
      chk("small_done", done_s, j == 10);
      chk("small_busy", busy_s, j <= 9);
    end

    repeat (2) drive(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_scan_ctrl.md
# tile_scan_ctrl

Frame-scan sequencer for the denoise/HOG tile datapath. It walks a 638×482 input frame in 14-column × 5-row tile windows: bands step 3 rows from the top, and tiles step 12 columns from the right edge. For each tile it issues a fetch request to the pixel source. It carries a valid/tag token down a delay line matched to the datapath latency, so the `valid`, `cnt_row` and `cnt_col` outputs line up with the datapath's `block_out_*` results.

## Interface
- `IMG_W`, default 638: input frame width in pixels.
- `IMG_H`, default 482: input frame height in pixels.
- `COL_STEP`, default 12: column stride between tiles.
- `ROW_STEP`, default 3: row stride between bands.
- `WIN_W`, default 14: tile window width.
- `WIN_H`, default 5: tile window height.
- `LAT`, default 4: datapath latency in cycles, from accepted pixel_in to block_out; must be ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle frame start request; honoured only in IDLE.
- `busy` out 1: high in SCAN and DRAIN.
- `done` out 1: one-cycle pulse at the end of a frame.
- `fetch_valid` out 1: tile request to the pixel source.
- `fetch_ready` in 1: the pixel source presents the tile's pixel_in this cycle.
- `fetch_row` out 9: top pixel row of the requested window.
- `fetch_col` out 10: leftmost-MSB column index (start_col) of the requested window.
- `pipe_in_valid` out 1: equals `fetch_valid & fetch_ready`; the datapath captures pixel_in on this edge.
- `valid` out 1: the `block_out_0..3` outputs of the datapath hold a tile result this cycle.
- `cnt_row` out 8: band index of the result, 0..159.
- `cnt_col` out 6: tile index within the band, 0..52.

## Operation
- Tile grid:
  - Bands: row = 0, 3, …, IMG_H−WIN_H, which gives 160 bands at default.
  - Columns: col = IMG_W−1, IMG_W−13, …, down to WIN_W−1, which gives 53 tiles per band at default (637 down to 13).
  - Total: 8480 tiles per frame.
- FSM states: IDLE → SCAN → DRAIN → DONE → IDLE.
  - IDLE: `fetch_valid`=0. `start`=1 moves to SCAN and loads row=0, col=IMG_W−1, band=0, tile=0.
  - SCAN: `fetch_valid`=1 with the current row/col.
    - On an accept edge (fetch_valid & fetch_ready): col −= COL_STEP and tile += 1.
    - If col was WIN_W−1: col wraps to IMG_W−1, tile to 0, row += ROW_STEP, band += 1.
    - Accepting the last tile (row IMG_H−WIN_H, col WIN_W−1) moves to DRAIN.
    - With no accept, the request holds stable; row/col must not change while fetch_valid=1 and fetch_ready=0.
  - DRAIN: `fetch_valid`=0. Wait until the delay line holds no valid token, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Delay line:
  - LAT stages, each holding {v, band[7:0], tile[5:0]}.
  - Stage 0 loads {pipe_in_valid, band, tile} every cycle; stalls enter as bubbles with v=0.
  - `valid` = v of the last stage.
  - `cnt_row`/`cnt_col` update from the last stage only when its v=1; otherwise they hold their last value.
- `start` outside IDLE is ignored; there is no queuing.
- Reset:
  - All outputs are 0, the state is IDLE, and every delay-line v is 0.
  - A reset mid-frame discards all in-flight tokens. No `valid` and no `done` follow.

## Timing
- `start` sampled at edge 0 → SCAN after edge 0; `fetch_valid` is high from that cycle.
- Accept at edge t → `valid` is high during the cycle between edges t+LAT−1 and t+LAT, carrying that tile's tags.
- Throughput is one tile per cycle when `fetch_ready` is held at 1.
- `done` goes high in the first cycle in which the delay line is empty after the last accept.
  - With LAT=4 and the last accept at edge t, `done` is high between edges t+4 and t+5.
  - `done` never coincides with `valid`.
- `fetch_row`/`fetch_col` are registered outputs. `pipe_in_valid` is combinational.

## Structure
- Shared package holds:
  - the frame constants IMG_W, IMG_H, WIN_W, WIN_H, COL_STEP, ROW_STEP;
  - the derived N_BANDS=160 and N_TILES=53;
  - the FSM state encoding;
  - the tag width constants (8/6).
- Sub-module `tag_delay_line`: a LAT-deep shift register of {v, tag}, exposing an `any_valid` OR-reduce used for the DRAIN exit.

## Test plan
- Full frame, `fetch_ready`=1, start at edge 0:
  - exactly 8480 `valid` cycles, contiguous;
  - the first valid carries (0,0) and starts after edge 4;
  - the last valid carries (159,52);
  - `done` is high between edges 8484 and 8485;
  - `busy` is low afterward.
- Band wrap: check the request sequence around tile 52 → next.
  - Expect (row 0, col 13), then (row 3, col 637).
  - `cnt_col` wraps 52→0 while `cnt_row` goes 0→1.
- Backpressure: toggle `fetch_ready` 1,0,0,1,… over the first 20 cycles.
  - `fetch_row`/`fetch_col` stay stable while stalled.
  - `valid` shows bubbles at the matching offsets.
  - Tags stay in order, with no tile skipped or duplicated.
- `start` pulsed during SCAN and during DRAIN: no effect on the sequence or the counts; a single `done` per frame.
- Assert `rst` at an arbitrary cycle mid-SCAN, with tokens in flight:
  - all outputs go to 0 immediately;
  - no `valid` or `done` appears afterward;
  - a new `start` produces a full, correct frame.
- Small-parameter frame (IMG_W=38, IMG_H=11, LAT=1):
  - 3 bands × 3 tiles;
  - the column sequence is 37, 25, 13;
  - `done` arrives 1 cycle after the last accept.
